mult_seq: RTL

Iterative radix-2 Booth multiplier for the EX stage. It takes two WIDTH-bit operands, signed or unsigned, and produces a 2·WIDTH-bit product over WIDTH+1 iterations. Each iteration drives one shared fa_nbit ripple adder. The block sits beside the ALU adder, and the pipeline stalls on `busy`.

---
 rtl/mult_pkg.sv | 26 ++
 rtl/fa_nbit.sv | 39 +++
 rtl/mult_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// ============================================================================
// Module      : mult_pkg
// Description : Shared types and helpers for the sequential Booth multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth pair {Q LSB, q_prev}
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fa_nbit.sv
// ============================================================================
// Module      : fa_nbit
// Description : Parameterised ripple-carry adder, cin enters at the LSB.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_nbit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             of
);

    logic w_carry;
    logic w_carry_msb;

    always_comb begin
        sum         = '0;
        w_carry     = cin;
        w_carry_msb = cin;
        for (int i = 0; i < WIDTH; i++) begin
            w_carry_msb = w_carry;
            sum[i]      = a[i] ^ b[i] ^ w_carry;
            w_carry     = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
        end
    end

    assign cout = w_carry;
    // Signed overflow: carry into the MSB differs from carry out of it.
    assign of   = w_carry ^ w_carry_msb;

endmodule

`default_nettype wire

// File: rtl/mult_seq.sv
// ============================================================================
// Module      : mult_seq
// Description : Iterative radix-2 Booth multiplier, WIDTH+1 iterations/product.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    output logic             busy,
    output logic             done,
    output logic [0:WIDTH-1] prod_hi,
    output logic [0:WIDTH-1] prod_lo,
    output logic             ovf
);

    localparam int             CW        = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH:0]     q_q, q_d;
    logic               qprev_q, qprev_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sgn_q, sgn_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               ovf_q, ovf_d;

    // Ports number bit 0 as MSB; internally everything is [N-1:0].
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [1:0]         w_pair;
    logic               w_sub;
    logic [WIDTH:0]     w_add_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_acc_upd;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_unused_cout;
    logic               w_unused_of;

    assign w_a     = a;
    assign w_b     = b;
    assign w_pair  = {q_q[0], qprev_q};
    assign w_sub   = (w_pair == BOOTH_SUB);
    assign w_add_b = w_sub ? ~m_q : m_q;

    fa_nbit #(
        .WIDTH (WIDTH + 1)
    ) u_add (
        .a    (acc_q),
        .b    (w_add_b),
        .cin  (w_sub),
        .sum  (w_sum),
        .cout (w_unused_cout),
        .of   (w_unused_of)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qprev_q <= 1'b0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qprev_q <= qprev_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qprev_d   = qprev_q;
        cnt_d     = cnt_q;
        sgn_d     = sgn_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        ovf_d     = ovf_q;
        busy      = 1'b0;
        done      = 1'b0;
        w_prod    = '0;
        w_acc_upd = (w_pair == BOOTH_ADD || w_pair == BOOTH_SUB) ? w_sum : acc_q;

        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    state_d = RUN;
                    m_d     = {is_signed & w_a[WIDTH-1], w_a};
                    q_d     = {is_signed & w_b[WIDTH-1], w_b};
                    acc_d   = '0;
                    qprev_d = 1'b0;
                    cnt_d   = '0;
                    sgn_d   = is_signed;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                busy    = 1'b1;
                acc_d   = {w_acc_upd[WIDTH], w_acc_upd[WIDTH:1]};
                q_d     = {w_acc_upd[0], q_q[WIDTH:1]};
                qprev_d = q_q[0];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    // Low 2*WIDTH bits of {A,Q} after the final shift.
                    w_prod  = {acc_d[WIDTH-2:0], q_d};
                    hi_d    = w_prod[2*WIDTH-1:WIDTH];
                    lo_d    = w_prod[WIDTH-1:0];
                    ovf_d   = sgn_q ? (hi_d != {WIDTH{lo_d[WIDTH-1]}})
                                    : (hi_d != '0);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign prod_hi = hi_q;
    assign prod_lo = lo_q;
    assign ovf     = ovf_q;

endmodule

`default_nettype wire
